// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared constants and types for the FIFO pointer/flag controller.
// Holds the default geometry, threshold defaults and the registered flag bundle.
package fifo_ptr_ctrl_pkg;

    localparam int unsigned AddrWDef    = 8;
    localparam int unsigned DepthDef    = 2 ** AddrWDef;
    localparam int unsigned AfThreshDef = 240;
    localparam int unsigned AeThreshDef = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t FlagsRst = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    // Occupancy and internal pointers carry one extra wrap bit.
    function automatic int unsigned cnt_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping (ADDR_W+1)-bit pointer register with increment enable.
// The MSB is the wrap bit used to tell full from empty.
module fifo_ptr_cnt #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    output logic [ADDR_W:0] ptr_o
);

    localparam logic [ADDR_W:0] PtrOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] ptr_q;
    logic [ADDR_W:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for a synchronous-write / asynchronous-read FIFO array.
// Occupancy is derived from the pointer difference; flags are registered from next occupancy.
module fifo_ptr_ctrl
    import fifo_ptr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = AddrWDef,
    parameter int unsigned AF_THRESH = AfThreshDef,
    parameter int unsigned AE_THRESH = AeThreshDef
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic              RD_EN,
    input  logic              CLR_ERR,
    output logic              WE,
    output logic [ADDR_W-1:0] WR_PTR,
    output logic [ADDR_W-1:0] RD_PTR,
    output logic              RD_VALID,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int unsigned     CntW   = cnt_width(ADDR_W);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] DepthC = CntW'(2 ** ADDR_W);
    localparam logic [CntW-1:0] AfC    = CntW'(AF_THRESH);
    localparam logic [CntW-1:0] AeC    = CntW'(AE_THRESH);

    logic [CntW-1:0] wr_ptr;
    logic [CntW-1:0] rd_ptr;
    logic [CntW-1:0] count_cur;
    logic [CntW-1:0] count_d;
    logic            wr_acc;
    logic            rd_acc;
    fifo_flags_t     flags_q;
    fifo_flags_t     flags_d;

    // A push while full is legal only alongside a pop: the head is consumed
    // combinationally and its slot is rewritten on the same edge.
    assign rd_acc = RD_EN & ~flags_q.empty;
    assign wr_acc = WR_EN & (~flags_q.full | RD_EN);

    fifo_ptr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (rd_acc),
        .ptr_o (rd_ptr)
    );

    assign count_cur = wr_ptr - rd_ptr;

    always_comb begin
        count_d = count_cur;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_cur + CntOne;
            2'b01:   count_d = count_cur - CntOne;
            default: count_d = count_cur;
        endcase
    end

    // Error flags are sticky; a fresh error in the clearing cycle wins.
    always_comb begin
        flags_d              = flags_q;
        flags_d.full         = (count_d == DepthC);
        flags_d.empty        = (count_d == '0);
        flags_d.almost_full  = (count_d >= AfC);
        flags_d.almost_empty = (count_d <= AeC);
        flags_d.overflow     = (WR_EN & ~wr_acc) | (flags_q.overflow & ~CLR_ERR);
        flags_d.underflow    = (RD_EN & flags_q.empty) | (flags_q.underflow & ~CLR_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags_q <= FlagsRst;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign WE           = wr_acc & ~RST;
    assign WR_PTR       = wr_ptr[ADDR_W-1:0];
    assign RD_PTR       = rd_ptr[ADDR_W-1:0];
    assign COUNT        = count_cur;
    assign RD_VALID     = ~flags_q.empty;
    assign FULL         = flags_q.full;
    assign EMPTY        = flags_q.empty;
    assign ALMOST_FULL  = flags_q.almost_full;
    assign ALMOST_EMPTY = flags_q.almost_empty;
    assign OVERFLOW     = flags_q.overflow;
    assign UNDERFLOW    = flags_q.underflow;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: a queue-based FIFO model predicts every cycle,
// a monitor process compares the DUT (plus a bench-side storage array) against it.
module tb_fifo_ptr_ctrl;

    localparam int Depth = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic        clr_err;
    logic [31:0] wdata;
    logic        we;
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic        rd_valid;
    logic [8:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    logic [31:0] mem [Depth];

    typedef struct {
        bit          we;
        int          wr_ptr;
        int          rd_ptr;
        int          count;
        bit          full;
        bit          empty;
        bit          af;
        bit          ae;
        bit          ovf;
        bit          udf;
        bit          hv;
        int unsigned head;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned mdl[$];
    int          n_wr;
    int          n_rd;
    bit          m_ovf;
    bit          m_udf;
    int          n_tests = 0;
    int          n_fail  = 0;

    fifo_ptr_ctrl u_dut (
        .CLK          (clk),
        .RST          (rst),
        .WR_EN        (wr_en),
        .RD_EN        (rd_en),
        .CLR_ERR      (clr_err),
        .WE           (we),
        .WR_PTR       (wr_ptr),
        .RD_PTR       (rd_ptr),
        .RD_VALID     (rd_valid),
        .COUNT        (count),
        .FULL         (full),
        .EMPTY        (empty),
        .ALMOST_FULL  (almost_full),
        .ALMOST_EMPTY (almost_empty),
        .OVERFLOW     (overflow),
        .UNDERFLOW    (underflow)
    );

    always #5 clk = ~clk;

    // Storage array driven by the DUT's write side.
    always @(posedge clk) begin
        if (we) mem[wr_ptr] <= wdata;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        n_wr  = 0;
        n_rd  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic step(input bit w, input bit r, input bit c);
        exp_t e;
        int   sz;
        bit   aw;
        bit   ar;
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        clr_err = c;
        wdata   = $urandom;
        sz = mdl.size();
        aw = w && (sz < Depth || r);
        ar = r && (sz > 0);
        if (ar) void'(mdl.pop_front());
        if (aw) begin
            mdl.push_back(wdata);
            n_wr++;
        end
        if (ar) n_rd++;
        m_ovf = (w && !aw) || (m_ovf && !c);
        m_udf = (r && sz == 0) || (m_udf && !c);
        e.we     = aw;
        e.wr_ptr = n_wr % Depth;
        e.rd_ptr = n_rd % Depth;
        e.count  = mdl.size();
        e.full   = (mdl.size() == Depth);
        e.empty  = (mdl.size() == 0);
        e.af     = (mdl.size() >= 240);
        e.ae     = (mdl.size() <= 16);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        e.hv     = (mdl.size() > 0);
        e.head   = (mdl.size() > 0) ? mdl[0] : 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ae"}, almost_empty, 1);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_udf"}, underflow, 0);
        chk({tag, "_wr_ptr"}, wr_ptr, 0);
        chk({tag, "_rd_ptr"}, rd_ptr, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_we"}, we, 0);
    endtask

    // Monitor: WE is checked mid-cycle, registered state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) continue;
            e = exp_q[0];
            chk("we", we, e.we);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("wr_ptr", wr_ptr, e.wr_ptr);
            chk("rd_ptr", rd_ptr, e.rd_ptr);
            chk("count", count, e.count);
            chk("full", full, e.full);
            chk("empty", empty, e.empty);
            chk("rd_valid", rd_valid, e.hv);
            chk("almost_full", almost_full, e.af);
            chk("almost_empty", almost_empty, e.ae);
            chk("overflow", overflow, e.ovf);
            chk("underflow", underflow, e.udf);
            chk("ptr_invariant", (int'(wr_ptr) - int'(rd_ptr) + Depth) % Depth, count % Depth);
            if (e.hv) chk("head_data", mem[rd_ptr], e.head);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wdata   = '0;
        model_reset();
        #3;
        chk_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        step(0, 0, 0);
        step(0, 0, 0);

        // Fill to full, crossing the almost-full threshold
        for (int i = 0; i < Depth; i++) step(1, 0, 0);
        // Push while full is rejected, then cleared
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        // Push+pop while full
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        // Drain to empty
        for (int i = 0; i < Depth; i++) step(0, 1, 0);
        // Push+pop on empty: write only, underflow
        step(1, 1, 0);
        step(0, 0, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Random traffic, then asynchronous reset mid-stream
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 5);
        end
        step(0, 0, 0);
        wait_drain();
        @(negedge clk);
        wr_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("mid_rst");
        @(negedge clk);
        chk("mid_rst_hold_count", count, 0);
        wr_en = 1'b0;
        rst   = 1'b0;
        model_reset();

        // 300 pushes and 300 pops, randomly interleaved
        cyc = 0;
        while ((n_wr < 300 || n_rd < 300) && cyc < 3000) begin
            step((n_wr < 300) && ($urandom_range(0, 99) < 55),
                 (n_rd < 300) && ($urandom_range(0, 99) < 50),
                 $urandom_range(0, 99) < 3);
            cyc++;
        end
        chk("interleave_pushes", n_wr, 300);
        chk("interleave_pops", n_rd, 300);
        step(0, 0, 0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer and flag controller for a 256-entry synchronous-write / asynchronous-read FIFO storage array.
- Accepts push/pop requests from the producer and consumer sides.
- Drives the array's write-enable, write pointer and read pointer.
- Reports occupancy, full/empty, thresholds and sticky error flags.
- First-word-fall-through: the array's read data equals the head entry whenever RD_VALID=1.

Parameters:
ADDR_W, 8, pointer width; DEPTH = 2**ADDR_W entries.
AF_THRESH, 240, ALMOST_FULL asserted when COUNT >= AF_THRESH.
AE_THRESH, 16, ALMOST_EMPTY asserted when COUNT <= AE_THRESH.

Ports:
CLK  input  1  clock, all state on rising edge.
RST  input  1  asynchronous, active-high reset.
WR_EN  input  1  producer push request.
RD_EN  input  1  consumer pop request.
CLR_ERR  input  1  clears OVERFLOW/UNDERFLOW.
WE  output  1  array write enable (combinational).
WR_PTR  output  ADDR_W  array write address.
RD_PTR  output  ADDR_W  array read address (head).
RD_VALID  output  1  head entry valid (= ~EMPTY).
COUNT  output  ADDR_W+1  occupancy, 0..DEPTH.
FULL  output  1  COUNT == DEPTH.
EMPTY  output  1  COUNT == 0.
ALMOST_FULL  output  1  threshold flag.
ALMOST_EMPTY  output  1  threshold flag.
OVERFLOW  output  1  sticky: push rejected.
UNDERFLOW  output  1  sticky: pop rejected.

Behaviour:
- Reset (async, RST=1): internal pointers=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0. WE forced 0 while RST=1.
- Internal pointers are ADDR_W+1 bits, the MSB being the wrap bit. WR_PTR/RD_PTR output the low ADDR_W bits. Pointers increment modulo 2**(ADDR_W+1), so 255 wraps to 0 on the outputs.
- rd_acc = RD_EN & ~EMPTY.
- wr_acc = WR_EN & (~FULL | RD_EN). A push while full is accepted only with a same-cycle pop: the head is read combinationally before the edge and the slot is overwritten at the edge.
- WE = wr_acc (combinational, same cycle as WR_EN). The array captures data at that rising edge.
- Each edge:
  - wr_acc: wr pointer +1.
  - rd_acc: rd pointer +1.
  - COUNT: +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither.
- FULL, EMPTY, ALMOST_* are registered, computed from next COUNT. They update on the same edge as COUNT (1-cycle latency from request).
- Empty with WR_EN=RD_EN=1: write accepted, read rejected (no bypass). UNDERFLOW sets; COUNT becomes 1.
- OVERFLOW sets on the edge where WR_EN=1 and wr_acc=0. UNDERFLOW sets on the edge where RD_EN=1 and EMPTY=1.
- Both error flags are sticky until CLR_ERR=1. If CLR_ERR and a new error occur in the same cycle, set wins.
- Rejected requests change no pointer and no COUNT.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). Array contents are not cleared and are treated as stale.
- Invariant: COUNT == (wr_ptr - rd_ptr) mod 2**(ADDR_W+1) at all times.

Decomposition:
- Shared package:
  - ADDR_W default.
  - DEPTH constant.
  - Default AF/AE thresholds.
  - COUNT width function ADDR_W+1.
- One natural sub-module, fifo_ptr_cnt, instantiated twice (write and read):
  - ADDR_W+1-bit wrapping pointer register.
  - Increment enable, async reset.

Test Plan:
- Reset then idle -> EMPTY=1, RD_VALID=0, COUNT=0, WR_PTR=RD_PTR=0, WE=0, ALMOST_EMPTY=1.
- 256 consecutive pushes -> WE high each cycle. After the edge for push 240, ALMOST_FULL=1. After push 256, FULL=1, COUNT=256, WR_PTR=0 (wrapped).
- Full, push alone -> WE=0, OVERFLOW=1, COUNT stays 256. Pulse CLR_ERR -> OVERFLOW=0.
- Full, push+pop same cycle -> WE=1, both pointers +1, COUNT stays 256, FULL stays 1, no OVERFLOW.
- Empty, push+pop same cycle -> COUNT=1, EMPTY=0, UNDERFLOW=1. Pop alone on empty -> UNDERFLOW set, RD_PTR unchanged.
- Write 300 then pop 300 in interleaved random order -> pointer invariant holds every cycle, array head matches the reference queue. Assert RST mid-stream -> all flags and pointers reset immediately.
